baud_detect: RTL and testbench

- Auto-baud detector: the receive-side counterpart of the baud generator.
- Measures the bit period of an incoming 0x55 sync character on the serial line.
- Reports clocks-per-bit and half-period counts, so a baud generator or UART can be loaded at runtime instead of using a fixed BAUD_RATE.
- Sits between the rx pad and the UART divisor configuration.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/baud_detect.sv | 161 ++++++++++++++++
 tb/tb_baud_detect.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive side: auto-baud FSM states and
// sync-character constants.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } bd_state_e;

   localparam logic [7:0]  SYNC_CHAR       = 8'h55;
   localparam int unsigned SYNC_FALL_EDGES = 32'd4;
   localparam int unsigned SYNC_BITS_LOG2  = 32'd3;

   // Absolute difference of two unsigned counts, widened to 32 bits.
   function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      if (a >= b) begin
         d = a - b;
      end else begin
         d = b - a;
      end
      return d;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reset value is
// configurable so an idle-high line powers up idle.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/baud_detect.sv
// Auto-baud detector: times the five falling edges of a 0x55 sync character
// and reports rounded clocks-per-bit plus the half period.
module baud_detect
   import uart_pkg::*;
#(
   parameter int unsigned CNT_W        = 32'd16,
   parameter int unsigned MIN_BIT_CLKS = 32'd8,
   parameter int unsigned TOL_SHIFT    = 32'd2
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             detect_en,
   input  logic             rx,
   output logic [CNT_W-1:0] bit_clks,
   output logic [CNT_W-1:0] half_clks,
   output logic             valid,
   output logic             error,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] MIN_CLKS  = CNT_W'(MIN_BIT_CLKS);
   localparam logic [CNT_W:0]   ROUND_ADD = (CNT_W+1)'(32'd1 << (SYNC_BITS_LOG2 - 32'd1));
   localparam logic [1:0]       LAST_EDGE = 2'(SYNC_FALL_EDGES - 32'd1);

   logic             rx_s;
   logic             rx_prev_q;
   logic             fall_s;

   bd_state_e        state_q;
   logic [CNT_W-1:0] total_q;
   logic [CNT_W-1:0] interval_q;
   logic [CNT_W-1:0] first_q;
   logic [1:0]       edge_cnt_q;
   logic [CNT_W-1:0] bit_clks_q;
   logic [CNT_W-1:0] half_clks_q;
   logic             valid_q;
   logic             error_q;
   logic             busy_q;

   logic [CNT_W-1:0] total_d;
   logic [CNT_W-1:0] interval_d;
   logic [CNT_W:0]   round_sum_s;
   logic [CNT_W-1:0] result_s;
   logic             tol_ok_s;

   sync_2ff #(
      .RST_VAL(1'b1)
   ) u_rx_sync (
      .clk_i (sys_clk),
      .rst_ni(reset),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   // Previous synchronized level for falling-edge detection.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         rx_prev_q <= 1'b1;
      end else begin
         rx_prev_q <= rx_s;
      end
   end

   assign fall_s      = rx_prev_q & ~rx_s;
   assign total_d     = total_q + CNT_ONE;
   assign interval_d  = interval_q + CNT_ONE;
   assign round_sum_s = {1'b0, total_q} + ROUND_ADD;
   assign result_s    = CNT_W'(round_sum_s >> SYNC_BITS_LOG2);
   assign tol_ok_s    = abs_diff(32'(interval_q), 32'(first_q)) <= 32'(first_q >> TOL_SHIFT);

   // Measurement FSM with registered result and status outputs.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         total_q     <= '0;
         interval_q  <= '0;
         first_q     <= '0;
         edge_cnt_q  <= 2'd0;
         bit_clks_q  <= '0;
         half_clks_q <= '0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         // Lags the state by one cycle so busy drops together with valid.
         busy_q  <= (state_q == ARMED) || (state_q == MEASURE);
         case (state_q)
            IDLE: begin
               if (detect_en && rx_s) begin
                  state_q <= ARMED;
               end else begin
                  state_q <= IDLE;
               end
            end
            ARMED: begin
               if (!detect_en) begin
                  state_q <= IDLE;
               end else if (fall_s) begin
                  state_q    <= MEASURE;
                  total_q    <= CNT_ONE;
                  interval_q <= CNT_ONE;
                  edge_cnt_q <= 2'd0;
               end else begin
                  state_q <= ARMED;
               end
            end
            MEASURE: begin
               if (!detect_en) begin
                  state_q <= IDLE;
               end else if (total_q == CNT_MAX) begin
                  error_q <= 1'b1;
                  state_q <= IDLE;
               end else if (fall_s) begin
                  if (edge_cnt_q == 2'd0) begin
                     first_q    <= interval_q;
                     total_q    <= total_d;
                     interval_q <= CNT_ONE;
                     edge_cnt_q <= edge_cnt_q + 2'd1;
                  end else if (!tol_ok_s) begin
                     error_q <= 1'b1;
                     state_q <= IDLE;
                  end else if (edge_cnt_q == LAST_EDGE) begin
                     state_q <= DONE;
                  end else begin
                     total_q    <= total_d;
                     interval_q <= CNT_ONE;
                     edge_cnt_q <= edge_cnt_q + 2'd1;
                  end
               end else begin
                  total_q    <= total_d;
                  interval_q <= interval_d;
               end
            end
            DONE: begin
               if (result_s >= MIN_CLKS) begin
                  bit_clks_q  <= result_s;
                  half_clks_q <= result_s >> 1;
                  valid_q     <= 1'b1;
               end else begin
                  error_q <= 1'b1;
               end
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bit_clks  = bit_clks_q;
   assign half_clks = half_clks_q;
   assign valid     = valid_q;
   assign error     = error_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_baud_detect.sv
// Self-checking bench for baud_detect: directed vector table, random frames
// against a frame-level model, and abort/timeout/reset sequences.
module tb_baud_detect;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic        detect_en;
   logic        rx;
   logic [15:0] bit_clks;
   logic [15:0] half_clks;
   logic        valid;
   logic        error;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int valid_cyc = 0;
   int fall5_cyc = 0;
   logic busy_at_valid = 1'b0;
   int unsigned lens[10];

   typedef struct {
      int unsigned even_len;
      int unsigned odd_len;
      int unsigned bit4_len;
      bit          exp_valid;
      int unsigned exp_bits;
   } vec_t;

   vec_t vecs[8];

   baud_detect dut (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .detect_en(detect_en),
      .rx       (rx),
      .bit_clks (bit_clks),
      .half_clks(half_clks),
      .valid    (valid),
      .error    (error),
      .busy     (busy)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (reset) begin
         if (valid) begin
            valid_cnt     <= valid_cnt + 1;
            valid_cyc     <= cyc;
            busy_at_valid <= busy;
         end
         if (error) err_cnt <= err_cnt + 1;
      end
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Drive frame bits [first..last] of a 0x55 character using lens[].
   task automatic drive_bits(input int first, input int last);
      logic [7:0] sync;
      sync = 8'h55;
      for (int i = first; i <= last; i++) begin
         if (i == 0) rx = 1'b0;
         else if (i == 9) rx = 1'b1;
         else rx = sync[i-1];
         if (i == 8) fall5_cyc = cyc;
         repeat (lens[i]) @(negedge sys_clk);
      end
   endtask

   task automatic rearm();
      detect_en = 1'b0;
      repeat (3) @(negedge sys_clk);
      detect_en = 1'b1;
      repeat (4) @(negedge sys_clk);
   endtask

   task automatic run_frame(output int dv, output int de);
      int v0, e0;
      v0 = valid_cnt;
      e0 = err_cnt;
      drive_bits(0, 9);
      repeat (12) @(negedge sys_clk);
      dv = valid_cnt - v0;
      de = err_cnt - e0;
   endtask

   // Frame-level reference: edge intervals are sums of bit pairs.
   function automatic void model_frame(output bit ok, output int unsigned res);
      int unsigned first, iv, d, total;
      first = lens[0] + lens[1];
      ok = 1'b1;
      for (int k = 1; k < 4; k++) begin
         iv = lens[2*k] + lens[2*k+1];
         d  = (iv > first) ? iv - first : first - iv;
         if (d > first / 4) ok = 1'b0;
      end
      total = 0;
      for (int i = 0; i < 8; i++) total += lens[i];
      res = (total + 4) / 8;
      if (res < 8) ok = 1'b0;
   endfunction

   initial begin
      int dv, de, v0, e0, waited;
      int unsigned model_bits, res, t, jmax;
      bit ok;

      vecs[0] = '{104, 104,   0, 1'b1, 104};
      vecs[1] = '{ 13,  14,   0, 1'b1,  14};
      vecs[2] = '{104, 104, 196, 1'b0,  14};
      vecs[3] = '{  8,   8,   0, 1'b1,   8};
      vecs[4] = '{  4,   4,   0, 1'b0,   8};
      vecs[5] = '{  7,   7,   0, 1'b0,   8};
      vecs[6] = '{104, 104, 156, 1'b1, 111};
      vecs[7] = '{104, 104, 157, 1'b0, 111};

      reset = 1'b0;
      detect_en = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("reset_bit_clks", int'(bit_clks), 0);
      check("reset_half_clks", int'(half_clks), 0);
      check("reset_valid", int'(valid), 0);
      check("reset_error", int'(error), 0);
      check("reset_busy", int'(busy), 0);
      reset = 1'b1;
      repeat (2) @(negedge sys_clk);

      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < 10; i++) lens[i] = (i % 2 == 0) ? vecs[v].even_len : vecs[v].odd_len;
         if (vecs[v].bit4_len != 0) lens[4] = vecs[v].bit4_len;
         rearm();
         run_frame(dv, de);
         check($sformatf("vec%0d_valid_cnt", v), dv, vecs[v].exp_valid ? 1 : 0);
         check($sformatf("vec%0d_error_cnt", v), de, vecs[v].exp_valid ? 0 : 1);
         check($sformatf("vec%0d_bit_clks", v), int'(bit_clks), int'(vecs[v].exp_bits));
         check($sformatf("vec%0d_half_clks", v), int'(half_clks), int'(vecs[v].exp_bits / 2));
         if (vecs[v].exp_valid) begin
            check($sformatf("vec%0d_latency", v), valid_cyc - fall5_cyc, 4);
            check($sformatf("vec%0d_busy_at_valid", v), int'(busy_at_valid), 0);
         end
      end
      model_bits = 111;

      for (int n = 0; n < 12; n++) begin
         t = $urandom_range(3, 30);
         case ($urandom_range(0, 2))
            0: jmax = 0;
            1: jmax = t / 8;
            default: jmax = t;
         endcase
         for (int i = 0; i < 10; i++) lens[i] = t + $urandom_range(0, jmax);
         lens[9] = t + 5;
         model_frame(ok, res);
         if (ok) model_bits = res;
         rearm();
         run_frame(dv, de);
         check($sformatf("rnd%0d_valid_cnt", n), dv, ok ? 1 : 0);
         check($sformatf("rnd%0d_error_cnt", n), de, ok ? 0 : 1);
         check($sformatf("rnd%0d_bit_clks", n), int'(bit_clks), int'(model_bits));
         check($sformatf("rnd%0d_half_clks", n), int'(half_clks), int'(model_bits / 2));
      end

      // Abort: detect_en drops after two falling edges.
      for (int i = 0; i < 10; i++) lens[i] = 20;
      rearm();
      v0 = valid_cnt;
      e0 = err_cnt;
      drive_bits(0, 3);
      check("abort_busy_mid", int'(busy), 1);
      detect_en = 1'b0;
      drive_bits(4, 9);
      repeat (12) @(negedge sys_clk);
      check("abort_valid_cnt", valid_cnt - v0, 0);
      check("abort_error_cnt", err_cnt - e0, 0);
      check("abort_busy", int'(busy), 0);

      // Timeout: line held low after the start edge.
      rearm();
      e0 = err_cnt;
      rx = 1'b0;
      waited = 0;
      for (int k = 0; k < 70000; k++) begin
         @(negedge sys_clk);
         waited = k + 1;
         if (err_cnt != e0) break;
      end
      check("timeout_error_cnt", err_cnt - e0, 1);
      check("timeout_len_ok", int'(waited >= 65530 && waited <= 65545), 1);
      repeat (3) @(negedge sys_clk);
      check("timeout_busy", int'(busy), 0);
      check("timeout_no_rearm_low", err_cnt - e0, 1);
      rx = 1'b1;
      repeat (5) @(negedge sys_clk);
      for (int i = 0; i < 10; i++) lens[i] = 104;
      run_frame(dv, de);
      check("resend_valid_cnt", dv, 1);
      check("resend_bit_clks", int'(bit_clks), 104);
      check("resend_half_clks", int'(half_clks), 52);

      // Reset in the middle of a frame.
      rearm();
      drive_bits(0, 4);
      reset = 1'b0;
      #1;
      check("midrst_bit_clks", int'(bit_clks), 0);
      check("midrst_half_clks", int'(half_clks), 0);
      check("midrst_valid", int'(valid), 0);
      check("midrst_error", int'(error), 0);
      check("midrst_busy", int'(busy), 0);
      rx = 1'b1;
      repeat (3) @(negedge sys_clk);
      reset = 1'b1;
      repeat (3) @(negedge sys_clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
